// File: rtl/elevator_ctrl_nfloor.sv
// N-floor collective-control elevator controller: latches hall/car calls, scans in the current direction while calls remain ahead.
// Latency: calls appear on pending one cycle after the input edge; IDLE decisions act one cycle after pending updates.
// Flow control: start_stop=0 freezes state, floor and timers while call latching continues; no other stall sources.
module elevator_ctrl_nfloor #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 200000000,
    parameter int DOOR_CYCLES   = 100000000,
    parameter int CNT_W         = 28
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               start_stop,
    input  logic [FLOORS-1:0]  hall_up,
    input  logic [FLOORS-1:0]  hall_down,
    input  logic [FLOORS-1:0]  car_call,
    output logic [FLOOR_W-1:0] floor,
    output logic [1:0]         state,
    output logic [FLOORS-1:0]  pending,
    output logic               door_open
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    // Top floor has no up button, ground floor has no down button.
    localparam logic [FLOORS-1:0] UP_MASK     = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_MASK     = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]  TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               last_up_q, last_up_d;
    logic [FLOORS-1:0]  up_q, up_d;
    logic [FLOORS-1:0]  dn_q, dn_d;
    logic [FLOORS-1:0]  car_q, car_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic               door_q, door_d;

    logic [FLOORS-1:0]  up_in, dn_in;
    logic [FLOORS-1:0]  clr_mask;
    logic [FLOOR_W-1:0] nxt_floor;
    logic               here, above, below, here_call;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i > int'(f))) any_above = 1'b1;
        end
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i < int'(f))) any_below = 1'b1;
        end
    endfunction

    function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        floor_bit    = '0;
        floor_bit[f] = 1'b1;
    endfunction

    // Next-state: scan decisions, timers and call latch set/clear.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        timer_d   = timer_q;
        last_up_d = last_up_q;
        clr_mask  = '0;
        nxt_floor = floor_q;

        up_in     = hall_up & UP_MASK;
        dn_in     = hall_down & DN_MASK;
        here      = pending_q[floor_q];
        above     = any_above(pending_q, floor_q);
        below     = any_below(pending_q, floor_q);
        here_call = up_in[floor_q] | dn_in[floor_q] | car_call[floor_q];

        if (start_stop) begin
            case (state_q)
                ST_IDLE: begin
                    if (here) begin
                        state_d  = ST_DOOR;
                        timer_d  = '0;
                        clr_mask = floor_bit(floor_q);
                    end else if (above && (last_up_q || !below)) begin
                        state_d   = ST_UP;
                        timer_d   = '0;
                        last_up_d = 1'b1;
                    end else if (below) begin
                        state_d   = ST_DOWN;
                        timer_d   = '0;
                        last_up_d = 1'b0;
                    end
                end
                ST_UP: begin
                    if (timer_q == TRAVEL_LAST) begin
                        nxt_floor = floor_q + FLOOR_W'(1);
                        floor_d   = nxt_floor;
                        timer_d   = '0;
                        if (pending_q[nxt_floor]) begin
                            state_d  = ST_DOOR;
                            clr_mask = floor_bit(nxt_floor);
                        end else if (!any_above(pending_q, nxt_floor)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (timer_q == TRAVEL_LAST) begin
                        nxt_floor = floor_q - FLOOR_W'(1);
                        floor_d   = nxt_floor;
                        timer_d   = '0;
                        if (pending_q[nxt_floor]) begin
                            state_d  = ST_DOOR;
                            clr_mask = floor_bit(nxt_floor);
                        end else if (!any_below(pending_q, nxt_floor)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                ST_DOOR: begin
                    // A call for the open floor is absorbed and holds the door
                    // open; it wins over a coincident close. While frozen the
                    // timer cannot restart, so such calls latch normally instead.
                    if (here_call) begin
                        timer_d  = '0;
                        clr_mask = floor_bit(floor_q);
                    end else if (timer_q == DOOR_LAST) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            endcase
        end

        // Clear has priority over a same-cycle set for the served floor.
        up_d      = (up_q  | up_in)    & ~clr_mask;
        dn_d      = (dn_q  | dn_in)    & ~clr_mask;
        car_d     = (car_q | car_call) & ~clr_mask;
        pending_d = up_d | dn_d | car_d;
        door_d    = (state_d == ST_DOOR);
    end

    // State, timer, call latches and registered indicator outputs.
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            timer_q   <= '0;
            last_up_q <= 1'b1;
            up_q      <= '0;
            dn_q      <= '0;
            car_q     <= '0;
            pending_q <= '0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            timer_q   <= timer_d;
            last_up_q <= last_up_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            car_q     <= car_d;
            pending_q <= pending_d;
            door_q    <= door_d;
        end
    end

    assign floor     = floor_q;
    assign state     = state_q;
    assign pending   = pending_q;
    assign door_open = door_q;

endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Bench for elevator_ctrl_nfloor: FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=4.
// Expected (floor, state, cycle) events are queued with each stimulus and popped
// as the car's floor/state change; direct point checks cover pending and door_open.
module tb_elevator_ctrl_nfloor;

    logic       clk_50mhz = 1'b0;
    logic       rst       = 1'b0;
    logic       start_stop;
    logic [3:0] hall_up, hall_down, car_call;
    logic [1:0] floor;
    logic [1:0] state;
    logic [3:0] pending;
    logic       door_open;

    typedef struct {
        int fl;
        int st;
        int cy;
    } evt_t;

    evt_t sb_q[$];
    evt_t mon_e;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   prev_fl = 0;
    int   prev_st = 0;
    int   c;

    elevator_ctrl_nfloor #(
        .FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .start_stop(start_stop),
        .hall_up   (hall_up),
        .hall_down (hall_down),
        .car_call  (car_call),
        .floor     (floor),
        .state     (state),
        .pending   (pending),
        .door_open (door_open)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every floor/state change must match the next queued event.
    always @(negedge clk_50mhz) begin
        if (!$isunknown({floor, state}) &&
            ((int'(floor) != prev_fl) || (int'(state) != prev_st))) begin
            if (sb_q.size() == 0) begin
                chk_eq("sb_extra_evt", int'(floor) * 4 + int'(state), -1);
            end else begin
                mon_e = sb_q.pop_front();
                chk_eq("evt_floor", int'(floor), mon_e.fl);
                chk_eq("evt_state", int'(state), mon_e.st);
                chk_eq("evt_cycle", cyc, mon_e.cy);
            end
            prev_fl <= int'(floor);
            prev_st <= int'(state);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50mhz);
            #2;
        end
    endtask

    task automatic exp_evt(input int fl, input int st, input int cy);
        evt_t e;
        e.fl = fl;
        e.st = st;
        e.cy = cy;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) step(1);
        chk_eq("sb_drain", sb_q.size(), 0);
    endtask

    // Async reset mid-cycle: outputs must be at reset values before any clock edge.
    task automatic pulse_reset(input bit moved);
        if (moved) exp_evt(0, 0, cyc);
        rst = 1'b0;
        #1;
        chk_eq("rst_floor", int'(floor), 0);
        chk_eq("rst_state", int'(state), 0);
        chk_eq("rst_pending", int'(pending), 0);
        chk_eq("rst_door", int'(door_open), 0);
        step(1);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        start_stop = 1'b1;
        hall_up    = '0;
        hall_down  = '0;
        car_call   = '0;

        // Reset then idle.
        step(3);
        chk_eq("reset_floor", int'(floor), 0);
        chk_eq("reset_state", int'(state), 0);
        chk_eq("reset_pending", int'(pending), 0);
        chk_eq("reset_door", int'(door_open), 0);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk_eq("idle_quiet", {int'(floor), int'(state), int'(pending), int'(door_open)} == 0 ? 0 : 1, 0);
        end

        // Single car call to the top floor.
        c = cyc;
        exp_evt(0, 1, c + 2);
        exp_evt(1, 1, c + 10);
        exp_evt(2, 1, c + 18);
        exp_evt(3, 3, c + 26);
        exp_evt(3, 0, c + 30);
        car_call = 4'b1000;
        step(1);
        car_call = '0;
        chk_eq("t2_pending", int'(pending), 8);
        step(1);
        chk_eq("t2_state_up", int'(state), 1);
        step(24);
        chk_eq("t2_door_pending", int'(pending), 0);
        chk_eq("t2_door_open", int'(door_open), 1);
        step(3);
        chk_eq("t2_door_last", int'(door_open), 1);
        step(1);
        chk_eq("t2_door_closed", int'(door_open), 0);
        wait_drain(20);

        pulse_reset(1'b1);

        // Collective scan: up through 2 and 3, then reverse to serve floor 1.
        c = cyc;
        exp_evt(0, 1, c + 2);
        exp_evt(1, 1, c + 10);
        exp_evt(2, 3, c + 18);
        exp_evt(2, 0, c + 22);
        exp_evt(2, 1, c + 23);
        exp_evt(3, 3, c + 31);
        exp_evt(3, 0, c + 35);
        exp_evt(3, 2, c + 36);
        exp_evt(2, 2, c + 44);
        exp_evt(1, 3, c + 52);
        exp_evt(1, 0, c + 56);
        car_call = 4'b1000;
        step(1);
        car_call = '0;
        step(10);
        chk_eq("t3_passing_floor", int'(floor), 1);
        hall_up   = 4'b0100;
        hall_down = 4'b0010;
        step(1);
        hall_up   = '0;
        hall_down = '0;
        chk_eq("t3_pending", int'(pending), 14);
        wait_drain(80);
        chk_eq("t3_final_pending", int'(pending), 0);

        // Door extend at floor 2 via a call for the open floor.
        c = cyc;
        exp_evt(1, 1, c + 2);
        exp_evt(2, 3, c + 10);
        exp_evt(2, 0, c + 18);
        car_call = 4'b0100;
        step(1);
        car_call = '0;
        step(12);
        hall_up = 4'b0100;
        step(1);
        hall_up = '0;
        chk_eq("t4_pending_not_latched", int'(pending), 0);
        chk_eq("t4_door_held", int'(door_open), 1);
        step(3);
        chk_eq("t4_door_extended", int'(door_open), 1);
        step(1);
        chk_eq("t4_door_closed", int'(door_open), 0);
        wait_drain(20);

        // Freeze mid-travel at timer=5 while latching a call below.
        c = cyc;
        exp_evt(2, 1, c + 2);
        exp_evt(3, 3, c + 30);
        exp_evt(3, 0, c + 34);
        exp_evt(3, 2, c + 35);
        exp_evt(2, 2, c + 43);
        exp_evt(1, 2, c + 51);
        exp_evt(0, 3, c + 59);
        exp_evt(0, 0, c + 63);
        car_call = 4'b1000;
        step(1);
        car_call = '0;
        step(6);
        start_stop = 1'b0;
        car_call   = 4'b0001;
        step(10);
        chk_eq("t5_frozen_floor", int'(floor), 2);
        chk_eq("t5_frozen_state", int'(state), 1);
        chk_eq("t5_frozen_pending", int'(pending), 9);
        step(10);
        start_stop = 1'b1;
        car_call   = '0;
        step(2);
        chk_eq("t5_not_yet", int'(floor), 2);
        step(1);
        chk_eq("t5_advanced", int'(floor), 3);
        wait_drain(60);

        // Ignored hall bits never latch.
        hall_down = 4'b0001;
        hall_up   = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_eq("t6_ignored_pending", int'(pending), 0);
            chk_eq("t6_ignored_state", int'(state), 0);
        end
        hall_down = '0;
        hall_up   = '0;

        // Async reset mid MOVE_UP at floor 2.
        c = cyc;
        exp_evt(0, 1, c + 2);
        exp_evt(1, 1, c + 10);
        exp_evt(2, 1, c + 18);
        car_call = 4'b1000;
        step(1);
        car_call = '0;
        step(19);
        chk_eq("t6_mid_floor", int'(floor), 2);
        chk_eq("t6_mid_state", int'(state), 1);
        pulse_reset(1'b1);
        step(5);
        chk_eq("t6_post_rst_pending", int'(pending), 0);
        chk_eq("t6_post_rst_state", int'(state), 0);
        wait_drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
